// File: rtl/regfile_pkg.sv
// Shared sizing constants and operand types for the datapath register file.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational operand read port: array select, r0 zero forcing and,
// when REGFILE_BYPASS_EN is defined, same-cycle forwarding of write-back data.
module regfile_read_port #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] regs_i [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
`endif
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_en_i && (wr_addr_i != '0) && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end
`endif
    // Belt and braces: r0 reads zero even if the array view ever changed.
    if (rd_addr_i == '0) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// r0 hardwired to zero. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module register_file #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] reg1_addr,
  input  logic [ADDR_WIDTH-1:0] reg2_addr,
  input  logic [ADDR_WIDTH-1:0] write_reg_addr,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] reg1_out,
  output logic [DATA_WIDTH-1:0] reg2_out
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // r0 has no storage at all, so a write to it simply has nowhere to land.
  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] word_q;
      logic [DATA_WIDTH-1:0] word_d;

      assign word_d = (write_enable && (write_reg_addr == ADDR_WIDTH'(gi)))
                      ? write_data : word_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign regs[gi] = word_q;
    end
  endgenerate

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_read_port1 (
    .rd_addr_i (reg1_addr),
    .regs_i    (regs),
`ifdef REGFILE_BYPASS_EN
    .wr_en_i   (write_enable),
    .wr_addr_i (write_reg_addr),
    .wr_data_i (write_data),
`endif
    .rd_data_o (reg1_out)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_read_port2 (
    .rd_addr_i (reg2_addr),
    .regs_i    (regs),
`ifdef REGFILE_BYPASS_EN
    .wr_en_i   (write_enable),
    .wr_addr_i (write_reg_addr),
    .wr_data_i (write_data),
`endif
    .rd_data_o (reg2_out)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations follow the
// REGFILE_BYPASS_EN setting of the build.
module tb_register_file;
  import regfile_pkg::*;

  logic      clk;
  logic      reset;
  reg_addr_t reg1_addr;
  reg_addr_t reg2_addr;
  reg_addr_t write_reg_addr;
  logic      write_enable;
  reg_data_t write_data;
  reg_data_t reg1_out;
  reg_data_t reg2_out;

  int errors = 0;
  int checks = 0;

  register_file dut (
    .clk            (clk),
    .reset          (reset),
    .reg1_addr      (reg1_addr),
    .reg2_addr      (reg2_addr),
    .write_reg_addr (write_reg_addr),
    .write_enable   (write_enable),
    .write_data     (write_data),
    .reg1_out       (reg1_out),
    .reg2_out       (reg2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input reg_data_t obs, input reg_data_t exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // One write committed on the rising edge between two falling edges.
  task automatic write_reg(input reg_addr_t addr, input reg_data_t data);
    @(negedge clk);
    write_reg_addr = addr;
    write_data     = data;
    write_enable   = 1'b1;
    @(negedge clk);
    write_enable   = 1'b0;
  endtask

  task automatic read_pair(input reg_addr_t a1, input reg_addr_t a2);
    reg1_addr = a1;
    reg2_addr = a2;
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    reg1_addr      = '0;
    reg2_addr      = '0;
    write_reg_addr = '0;
    write_enable   = 1'b0;
    write_data     = '0;

    // Reset state
    read_pair(5'd0, 5'd5);
    check_value("rst_r0", reg1_out, 32'h0000_0000);
    check_value("rst_r5", reg2_out, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b1;

    // Basic write/read
    write_reg(5'd2, 32'h1234_5678);
    read_pair(5'd0, 5'd2);
    check_value("basic_r0", reg1_out, 32'h0000_0000);
    check_value("basic_r2", reg2_out, 32'h1234_5678);

    // Register 0 immutable
    write_reg(5'd0, 32'hABCD_EFFA);
    read_pair(5'd0, 5'd0);
    check_value("r0_port1", reg1_out, 32'h0000_0000);
    check_value("r0_port2", reg2_out, 32'h0000_0000);

    // Write enable gating across two edges
    @(negedge clk);
    write_reg_addr = 5'd5;
    write_data     = 32'hDEAD_BEEF;
    write_enable   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    read_pair(5'd5, 5'd2);
    check_value("gate_r5", reg1_out, 32'h0000_0000);
    check_value("gate_r2_hold", reg2_out, 32'h1234_5678);

    // Dual port and address boundaries
    write_reg(5'd31, 32'hFFFF_FFFF);
    write_reg(5'd1, 32'h0000_0001);
    read_pair(5'd31, 5'd1);
    check_value("dual_r31", reg1_out, 32'hFFFF_FFFF);
    check_value("dual_r1", reg2_out, 32'h0000_0001);

    // Same-cycle read and write of r7
    write_reg(5'd7, 32'h1111_2222);
    @(negedge clk);
    write_reg_addr = 5'd7;
    write_data     = 32'hCAFE_F00D;
    write_enable   = 1'b1;
    read_pair(5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
    check_value("rw_pre_p1", reg1_out, 32'hCAFE_F00D);
    check_value("rw_pre_p2", reg2_out, 32'hCAFE_F00D);
`else
    check_value("rw_pre_p1", reg1_out, 32'h1111_2222);
    check_value("rw_pre_p2", reg2_out, 32'h1111_2222);
`endif
    @(posedge clk);
    #1;
    check_value("rw_post_p1", reg1_out, 32'hCAFE_F00D);
    check_value("rw_post_p2", reg2_out, 32'hCAFE_F00D);
    @(negedge clk);
    write_enable = 1'b0;

    // A pending write to r0 must never forward
    write_reg_addr = 5'd0;
    write_data     = 32'h5555_AAAA;
    write_enable   = 1'b1;
    read_pair(5'd0, 5'd7);
    check_value("wr0_fwd_r0", reg1_out, 32'h0000_0000);
    check_value("wr0_r7", reg2_out, 32'hCAFE_F00D);
    write_enable = 1'b0;

    // Reset asserted mid-write: reset wins
    @(negedge clk);
    write_reg_addr = 5'd3;
    write_data     = 32'h3333_3333;
    write_enable   = 1'b1;
    reset          = 1'b0;
    read_pair(5'd2, 5'd31);
    check_value("rst_mid_r2", reg1_out, 32'h0000_0000);
    check_value("rst_mid_r31", reg2_out, 32'h0000_0000);
    @(posedge clk);
    #1;
    read_pair(5'd3, 5'd1);
    check_value("rst_mid_r3", reg1_out, 32'h0000_0000);
    check_value("rst_mid_r1", reg2_out, 32'h0000_0000);
    @(negedge clk);
    write_enable = 1'b0;
    reset        = 1'b1;

    // Reset pulse of 10 ns after fresh writes
    write_reg(5'd2, 32'h0BAD_F00D);
    write_reg(5'd31, 32'h8000_0001);
    #2;
    reset = 1'b0;
    #10;
    reset = 1'b1;
    read_pair(5'd0, 5'd1);
    check_value("pulse_r0", reg1_out, 32'h0000_0000);
    check_value("pulse_r1", reg2_out, 32'h0000_0000);
    read_pair(5'd2, 5'd31);
    check_value("pulse_r2", reg1_out, 32'h0000_0000);
    check_value("pulse_r31", reg2_out, 32'h0000_0000);

    // Writes resume after reset release
    write_reg(5'd4, 32'h4444_0004);
    read_pair(5'd4, 5'd7);
    check_value("resume_r4", reg1_out, 32'h4444_0004);
    check_value("resume_r7", reg2_out, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
